// File: rtl/execute_mdu_ctrl_pkg.sv
// execute_mdu_ctrl_pkg: shared funct3 codes, FSM state type and default width for the M-extension unit.
package execute_mdu_ctrl_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} mdu_state_e;
endpackage

// File: rtl/execute_mdu_ctrl_if.sv
// execute_mdu_ctrl_if: execute-stage <-> MDU bundle.
// master (pipeline): drives start/funct3/operands/flush; sees busy/done/result.
// slave (MDU): the reverse.
interface execute_mdu_ctrl_if import execute_mdu_ctrl_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT
);
  logic            i_mdu_start;
  logic [2:0]      i_mdu_funct3;
  logic [XLEN-1:0] i_mdu_operand_a;
  logic [XLEN-1:0] i_mdu_operand_b;
  logic            i_mdu_flush;
  logic            o_mdu_busy;
  logic            o_mdu_done;
  logic [XLEN-1:0] o_mdu_result;
  modport master (
    output i_mdu_start, i_mdu_funct3, i_mdu_operand_a, i_mdu_operand_b, i_mdu_flush,
    input  o_mdu_busy, o_mdu_done, o_mdu_result
  );
  modport slave (
    input  i_mdu_start, i_mdu_funct3, i_mdu_operand_a, i_mdu_operand_b, i_mdu_flush,
    output o_mdu_busy, o_mdu_done, o_mdu_result
  );
endinterface

// File: rtl/execute_mdu_step.sv
// execute_mdu_step: one combinational iteration of shift-add multiply or restoring divide.
// acc: {hi, lo} working accumulator; opnd: multiplicand (mul) or divisor (div);
// op_bit: current multiplier bit (LSB first) or dividend bit (MSB first); acc_next: updated accumulator.
module execute_mdu_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,
  input  logic              op_bit,
  output logic [2*XLEN-1:0] acc_next
);
  logic [XLEN:0]   sum;
  logic [XLEN:0]   partial;
  logic            ge;
  logic [XLEN-1:0] rem_new;
  always_comb begin
    // multiply: hi += opnd when the multiplier bit is set, then shift {carry,hi,lo} right
    sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (op_bit ? {1'b0, opnd} : '0);
    // divide: remainder lives in hi, quotient bits shift into lo
    partial  = {acc[2*XLEN-1:XLEN], op_bit};
    ge       = partial >= {1'b0, opnd};
    rem_new  = ge ? XLEN'(partial - {1'b0, opnd}) : partial[XLEN-1:0];
    acc_next = is_div ? {rem_new, acc[XLEN-2:0], ge} : {sum, acc[XLEN-1:1]};
  end
endmodule

// File: rtl/execute_mdu_ctrl.sv
// execute_mdu_ctrl: iterative RV32M multiply/divide unit with stall/done sequencing.
// i_mdu_clk: clock; i_mdu_reset_n: async active-low reset;
// mdu (slave): start/funct3/operands/flush in, busy (comb stall), done (1-cycle pulse), result (registered) out.
module execute_mdu_ctrl import execute_mdu_ctrl_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT
) (
  input logic              i_mdu_clk,
  input logic              i_mdu_reset_n,
  execute_mdu_ctrl_if.slave mdu
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
  mdu_state_e        state, state_next;
  logic [CW-1:0]     count;
  logic [2:0]        f3;
  logic              neg_a, neg_b;
  logic [XLEN-1:0]   mag_a, mag_b, result;
  logic [2*XLEN-1:0] acc, acc_next, prod;
  logic              sign_a, sign_b, div0, ovf, special, op_bit;
  logic [XLEN-1:0]   special_res, quo, rem, fixed, opnd;
  always_comb begin
    sign_a      = mdu.i_mdu_funct3 inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
    sign_b      = mdu.i_mdu_funct3 inside {MDU_MULH, MDU_DIV, MDU_REM};
    div0        = mdu.i_mdu_funct3[2] & (mdu.i_mdu_operand_b == '0);
    ovf         = (mdu.i_mdu_funct3 inside {MDU_DIV, MDU_REM}) & (mdu.i_mdu_operand_a == MIN_INT)
                  & (mdu.i_mdu_operand_b == '1);
    special     = div0 | ovf;
    // funct3[1] separates REM/REMU from DIV/DIVU among the divide ops
    special_res = div0 ? (mdu.i_mdu_funct3[1] ? mdu.i_mdu_operand_a : '1)
                       : (mdu.i_mdu_funct3[1] ? '0 : MIN_INT);
    state_next  = mdu.i_mdu_flush ? IDLE
                : state == IDLE ? (mdu.i_mdu_start ? (special ? DONE : CALC) : IDLE)
                : state == CALC ? (count == CW'(XLEN - 1) ? FIX : CALC)
                : state == FIX  ? DONE : IDLE;
    mdu.o_mdu_busy   = i_mdu_reset_n & ~mdu.i_mdu_flush
                       & (((state == IDLE) & mdu.i_mdu_start) | (state == CALC) | (state == FIX));
    mdu.o_mdu_done   = ~mdu.i_mdu_flush & (state == DONE);
    mdu.o_mdu_result = result;
    // XLEN is a power of two, so XLEN-1-count is the bitwise complement of the index bits
    op_bit = f3[2] ? mag_a[~count[CW-2:0]] : mag_b[count[CW-2:0]];
    opnd   = f3[2] ? mag_b : mag_a;
    prod   = (neg_a ^ neg_b) ? -acc : acc;
    quo    = (neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem    = neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    fixed  = f3[2] ? (f3[1] ? rem : quo) : (f3 == MDU_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  end
  execute_mdu_step #(.XLEN(XLEN)) u_step (
    .is_div  (f3[2]),
    .acc     (acc),
    .opnd    (opnd),
    .op_bit  (op_bit),
    .acc_next(acc_next)
  );
  always_ff @(posedge i_mdu_clk or negedge i_mdu_reset_n)
    if (!i_mdu_reset_n) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge i_mdu_clk or negedge i_mdu_reset_n) begin
    if (!i_mdu_reset_n) begin
      count  <= '0;
      f3     <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      acc    <= '0;
      result <= '0;
    end else if (mdu.i_mdu_flush) begin
      count <= '0;
    end else if (state == IDLE && mdu.i_mdu_start) begin
      f3    <= mdu.i_mdu_funct3;
      neg_a <= sign_a & mdu.i_mdu_operand_a[XLEN-1];
      neg_b <= sign_b & mdu.i_mdu_operand_b[XLEN-1];
      mag_a <= (sign_a & mdu.i_mdu_operand_a[XLEN-1]) ? -mdu.i_mdu_operand_a : mdu.i_mdu_operand_a;
      mag_b <= (sign_b & mdu.i_mdu_operand_b[XLEN-1]) ? -mdu.i_mdu_operand_b : mdu.i_mdu_operand_b;
      acc   <= '0;
      count <= '0;
      if (special) result <= special_res;
    end else if (state == CALC) begin
      acc   <= acc_next;
      count <= count + CW'(1);
    end else if (state == FIX) begin
      result <= fixed;
    end
  end
endmodule
